// File: rtl/led_shift_controller_if.sv
// rtl/led_shift_controller_if.sv - button/pattern/LED signal bundle for led_shift_controller
interface led_shift_controller_if #(
  parameter int LEDS = 8
);
  logic            button;
  logic [1:0]      mode_sel;
  logic            data_in;
  logic            load;
  logic [LEDS-1:0] load_data;
  logic            pause;
  logic [LEDS-1:0] leds;
  logic            direction;
  logic            tick;

  modport master (
    output button, mode_sel, data_in, load, load_data, pause,
    input  leds, direction, tick
  );

  modport slave (
    input  button, mode_sel, data_in, load, load_data, pause,
    output leds, direction, tick
  );
endinterface

// File: rtl/led_shift_controller.sv
// rtl/led_shift_controller.sv - rate-divided shift/rotate/bounce/hold LED pattern engine
module led_shift_controller #(
  parameter int LEDS            = 8,
  parameter int TICK_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  led_shift_controller_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [PW-1:0]   presc;
  logic            s1, s2;
  logic            deb;
  logic [DW-1:0]   deb_cnt;
  logic [LEDS-1:0] leds_q;
  logic            dir_q;

  logic            tick;
  logic            deb_next;
  logic            btn_rise;
  logic            step;
  logic            flip;
  logic            step_dir;
  logic            fill_lo;
  logic            fill_hi;
  logic [LEDS-1:0] step_val;

  assign tick          = (presc == PRESC_MAX);
  assign bus.tick      = tick;
  assign bus.leds      = leds_q;
  assign bus.direction = dir_q;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.button;
      s2 <= s1;
    end
  end

  // Debounced level adopts s2 once it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    deb_next = deb;
    if (s2 != deb && deb_cnt == DEB_MAX)
      deb_next = s2;
  end

  assign btn_rise = deb_next & ~deb;

  // Debounce counter and debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb <= deb_next;
      if (s2 == deb || deb_cnt == DEB_MAX)
        deb_cnt <= '0;
      else
        deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Free-running prescaler; a load restarts the step interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (bus.load || tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  // Next pattern for a step; bounce rotates using the already-flipped direction
  always_comb begin
    step     = tick & ~bus.load & ~bus.pause & (bus.mode_sel != MODE_HOLD);
    flip     = (bus.mode_sel == MODE_BOUNCE) & (dir_q ? leds_q[0] : leds_q[LEDS-1]);
    step_dir = dir_q ^ flip;
    if (bus.mode_sel == MODE_SHIFT) begin
      fill_lo = bus.data_in;
      fill_hi = bus.data_in;
    end else begin
      fill_lo = leds_q[LEDS-1];
      fill_hi = leds_q[0];
    end
    if (step_dir)
      step_val = {fill_hi, leds_q[LEDS-1:1]};
    else
      step_val = {leds_q[LEDS-2:0], fill_lo};
  end

  // Pattern and direction registers; button toggle and bounce flip combine by XOR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      dir_q <= dir_q ^ btn_rise ^ (step & flip);
      if (bus.load)
        leds_q <= bus.load_data;
      else if (step)
        leds_q <= step_val;
    end
  end

endmodule

// File: tb/tb_led_shift_controller.sv
// tb/tb_led_shift_controller.sv - vector table plus scoreboard bench for led_shift_controller
module tb_led_shift_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  led_shift_controller_if #(.LEDS(8)) bus ();

  led_shift_controller #(
    .LEDS(8),
    .TICK_DIV(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       ld;
    logic [7:0] ld_data;
    logic [1:0] mode;
    logic       din;
    logic       pse;
    logic       exp_tick;
    logic [7:0] exp_leds;
    logic       exp_dir;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] leds;
    logic       dir;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void add(input logic ld, input logic [7:0] ld_data, input logic [1:0] mode,
                              input logic din, input logic pse, input logic t,
                              input logic [7:0] l, input logic d);
    vec_t v;
    v.ld = ld; v.ld_data = ld_data; v.mode = mode; v.din = din; v.pse = pse;
    v.exp_tick = t; v.exp_leds = l; v.exp_dir = d;
    vecs.push_back(v);
  endfunction

  task automatic push_exp(input string name, input logic [7:0] l, input logic d);
    exp_t e;
    e.name = name; e.leds = l; e.dir = d;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      cmp({e.name, "_leds"}, 32'(bus.leds), 32'(e.leds));
      cmp({e.name, "_dir"}, 32'(bus.direction), 32'(e.dir));
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  int   toggles;
  logic last_dir;

  initial begin
    bus.button = 0; bus.mode_sel = 0; bus.data_in = 0;
    bus.load = 0; bus.load_data = 0; bus.pause = 0;

    // ---------------- reset state ----------------
    edges(3);
    cmp("reset_leds", 32'(bus.leds), 32'h0);
    cmp("reset_dir", 32'(bus.direction), 32'h0);
    cmp("reset_tick", 32'(bus.tick), 32'h0);

    // ---------------- vector table ----------------
    for (int k = 1; k <= 12; k++)
      add(0, 8'h00, 2'b00, 1, 0, (k % 4 == 0),
          (k < 4) ? 8'h00 : (k < 8) ? 8'h01 : (k < 12) ? 8'h03 : 8'h07, 0);
    add(1, 8'h40, 2'b10, 0, 0, 0, 8'h40, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 8'h00, 2'b10, 0, 0, (k % 4 == 0),
          (k < 4) ? 8'h40 : (k < 8) ? 8'h80 : (k < 12) ? 8'h40 : 8'h20, (k >= 8));
    for (int k = 1; k <= 12; k++)
      add(0, 8'h00, 2'b00, 1, 1, (k % 4 == 0), 8'h20, 1);
    add(1, 8'h5A, 2'b00, 1, 1, 0, 8'h5A, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 8'h00, 2'b11, 1, 0, (k % 4 == 0), 8'h5A, 1);
    for (int k = 1; k <= 4; k++)
      add(0, 8'h00, 2'b01, 0, 0, (k == 4), (k < 4) ? 8'h5A : 8'h2D, 1);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.load = vecs[i].ld; bus.load_data = vecs[i].ld_data;
      bus.mode_sel = vecs[i].mode; bus.data_in = vecs[i].din; bus.pause = vecs[i].pse;
      cmp($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].exp_tick));
      push_exp($sformatf("vec%0d", i), vecs[i].exp_leds, vecs[i].exp_dir);
      edge1();
      pop_check();
    end
    bus.load = 0; bus.pause = 0;

    // ---------------- async reset mid-step ----------------
    bus.load = 1; bus.load_data = 8'h3C; bus.mode_sel = 2'b11;
    push_exp("load_3c", 8'h3C, 1);
    edge1();
    pop_check();
    bus.load = 0;
    edges(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_leds", 32'(bus.leds), 32'h0);
    cmp("async_rst_dir", 32'(bus.direction), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mode_sel = 2'b00; bus.data_in = 1;
    edges(3);
    cmp("post_rst_e3_leds", 32'(bus.leds), 32'h0);
    cmp("post_rst_e3_tick", 32'(bus.tick), 32'h1);
    edge1();
    cmp("post_rst_e4_leds", 32'(bus.leds), 32'h01);

    // ---------------- rotate and button press ----------------
    bus.load = 1; bus.load_data = 8'h81; bus.mode_sel = 2'b01; bus.data_in = 0;
    push_exp("rot_load", 8'h81, 0);
    edge1();
    pop_check();
    bus.load = 0;
    edges(3);
    cmp("rot_e3_leds", 32'(bus.leds), 32'h81);
    push_exp("rot_step", 8'h03, 0);
    edge1();
    pop_check();
    bus.button = 1;
    edges(5);
    cmp("press10_e5_dir", 32'(bus.direction), 32'h0);
    edge1();
    cmp("press10_e6_dir", 32'(bus.direction), 32'h1);
    edges(4);
    bus.button = 0;
    edges(10);
    cmp("release_dir", 32'(bus.direction), 32'h1);
    bus.load = 1; bus.load_data = 8'h81;
    edge1();
    bus.load = 0;
    edges(3);
    push_exp("rot_right", 8'hC0, 1);
    edge1();
    pop_check();

    // ---------------- debounce corner cases ----------------
    bus.mode_sel = 2'b11;
    bus.button = 1;
    edges(3);
    bus.button = 0;
    edges(10);
    cmp("short3_dir", 32'(bus.direction), 32'h1);
    bus.button = 1;
    edges(5);
    cmp("press6_e5_dir", 32'(bus.direction), 32'h1);
    edge1();
    cmp("press6_e6_dir", 32'(bus.direction), 32'h0);
    bus.button = 0;
    edges(10);
    cmp("press6_release_dir", 32'(bus.direction), 32'h0);

    toggles = 0;
    last_dir = bus.direction;
    for (int k = 0; k < 30; k++) begin
      bus.button = (k < 20) ? logic'(k % 2) : 1'b1;
      edge1();
      if (bus.direction !== last_dir) toggles++;
      last_dir = bus.direction;
    end
    cmp("bounce_train_toggles", 32'(toggles), 32'd1);
    cmp("bounce_train_dir", 32'(bus.direction), 32'h1);
    bus.button = 0;
    edges(10);
    cmp("bounce_train_hold_leds", 32'(bus.leds), 32'hC0);
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/led_shift_controller.md
# led_shift_controller

Parametrised LED pattern engine driving a bank of `LEDS` outputs from a single push-button and a serial/parallel data source. It replaces the fixed serial shifter with a rate-divided, multi-mode engine with four modes: shift, rotate, bounce and hold. It adds a debounced direction toggle, parallel load and pause. It sits between the board's raw button/switch inputs and the LED pins, in the same clock domain as the rest of the chapter designs.

## Interface
- `LEDS`, 8, number of LED outputs; must be ≥ 2.
- `TICK_DIV`, 4, clock cycles per shift step; must be ≥ 1 (1 = shift every cycle).
- `DEBOUNCE_CYCLES`, 4, consecutive stable cycles required to accept a button level change; must be ≥ 1.

- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button`  in  1  raw, asynchronous, bouncy push-button; each press toggles direction.
- `mode_sel`  in  2  00 shift, 01 rotate, 10 bounce, 11 hold.
- `data_in`  in  1  serial bit entering the pattern in shift mode.
- `load`  in  1  synchronous parallel load strobe.
- `load_data`  in  LEDS  value loaded when `load`=1.
- `pause`  in  1  suppresses shift steps while high.
- `leds`  out  LEDS  current pattern (registered).
- `direction`  out  1  0 = toward MSB, 1 = toward LSB (registered).
- `tick`  out  1  one-cycle step strobe from the prescaler.

## Operation
- Reset (async, `rst_n`=0): `leds`=0, `direction`=0, prescaler=0, synchroniser FFs=0, debounced level=0, debounce counter=0. Outputs take these values immediately, without waiting for a clock edge.
- Button path:
  - 2-FF synchroniser (`s1`→`s2`), then a debouncer.
  - The debounce counter clears whenever `s2` equals the debounced level and increments otherwise.
  - When the counter is at DEBOUNCE_CYCLES−1 and `s2` still differs, the debounced level takes the `s2` value on that edge.
  - A 0→1 change of the debounced level toggles `direction` on the same edge. A 1→0 change (release) has no effect.
- Prescaler:
  - Free-runs 0..TICK_DIV−1 and wraps. It is not stopped by `pause` or hold mode.
  - `tick` is combinational, high while prescaler = TICK_DIV−1.
- Step: performed on the rising edge where `tick`=1, `load`=0, `pause`=0 and `mode_sel`≠11. Uses the registered `direction`.
  - Shift, dir 0: `leds` ← {`leds`[LEDS−2:0], `data_in`}.
  - Shift, dir 1: `leds` ← {`data_in`, `leds`[LEDS−1:1]}.
  - Rotate: same as shift, but the bit falling off the end re-enters at the other end instead of `data_in`.
  - Bounce: rotate, with one addition.
    - If dir 0 and `leds`[LEDS−1]=1, or dir 1 and `leds`[0]=1: `direction` flips and the rotate on that edge uses the new direction.
    - A pattern with both end bits set flips every step; this is legal.
  - Hold: `leds` is unchanged.
- Load:
  - `load`=1 sets `leds` ← `load_data` and prescaler ← 0.
  - It has priority over a step and is honoured during `pause` and in hold mode.
- Simultaneous button toggle and bounce flip on the same edge: the two effects XOR. The net `direction` equals the old value when both occur. The step on that edge uses the bounce-adjusted direction only.
- A `mode_sel` change takes effect at the next step. No pattern state is cleared.

## Timing
- Button latency: the edge that first samples `button`=1 is edge 1. `direction` toggles on edge 2+DEBOUNCE_CYCLES, provided `s2` stays high for DEBOUNCE_CYCLES consecutive cycles.
- A pulse that keeps `s2` high for fewer than DEBOUNCE_CYCLES cycles is ignored.
- Release needs DEBOUNCE_CYCLES stable low cycles before the next press can register.
- After reset release, the first step happens on edge TICK_DIV; steps then recur every TICK_DIV edges.
- After a load on edge N, the next step happens on edge N+TICK_DIV.
- `leds` and `direction` change only on `clk` rising edges, except under async reset.

## Test plan
All scenarios use LEDS=8, TICK_DIV=4 and DEBOUNCE_CYCLES=4.
- Reset, mode 00, `data_in`=1, dir 0 -> `leds` = 0x01, 0x03, 0x07 on edges 4, 8, 12. `tick` is high in the cycle preceding each of these edges.
- Load 0x81, mode 01, dir 0 -> next step gives 0x03. Then press the button for 10 cycles -> `direction`=1 on edge 6 after first sample. Reload 0x81 -> next step gives 0xC0.
- Load 0x40, mode 10, dir 0 -> steps give 0x80, then 0x40 with `direction`=1, then 0x20. The `direction` flip is visible on the 0x80→0x40 edge.
- Button high for 3 cycles then low -> no toggle. Button high for 6 cycles -> exactly one toggle, on edge 6. A bounce train of 1-cycle pulses (0/1 alternating for 20 cycles) followed by a stable high -> exactly one toggle.
- `pause`=1 for 12 cycles, or mode 11 -> `leds` unchanged while `tick` keeps pulsing every 4 cycles. Load 0x5A during `pause` -> `leds`=0x5A on the next edge.
- Assert `rst_n`=0 mid-step with `leds`=0x3C and `direction`=1 -> `leds`=0 and `direction`=0 with no clock edge. After release, the first step occurs on edge 4.
